// File: rtl/eka_lsu.sv
// rtl/eka_lsu.sv - Eka load/store unit: sized core accesses to word-aligned memory handshake
//
// Turns RV32I byte/halfword/word loads and stores into word-aligned memory
// requests with byte enables. It replicates store data across lanes and
// sign/zero-extends load data. Misaligned or illegal accesses complete as a
// fault without a memory transaction.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   core_req/wr/funct3   core request, store flag, RV32I width code
//   core_addr/wr_data    byte address and store data
//   core_rd_data         formatted load result (held until the next load)
//   core_stall           combinational stall while a request is in progress
//   core_done/fault      one-cycle completion pulse, fault qualifier
//   mem_req/we/addr      memory request (held until mem_ack), write enable, word address
//   mem_be/wr_data       byte lane enables and lane-replicated store data
//   mem_ack/rd_data      memory completion and read word
module eka_lsu #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_wr,
    input  logic [2:0]            core_funct3,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wr_data,
    output logic [31:0]           core_rd_data,
    output logic                  core_stall,
    output logic                  core_done,
    output logic                  core_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wr_data,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [2:0]            funct3_q;
    logic [31:0]           data_q;
    logic                  fault_q;
    logic [31:0]           rd_data_q;

    logic                  accept;
    logic                  req_fault;
    logic [3:0]            be_fmt;
    logic [31:0]           wd_fmt;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_fmt;

    assign accept = (state_q == S_IDLE) && core_req;

    // Fault classification of the incoming request (illegal width or misaligned).
    always_comb begin
        req_fault = 1'b0;
        case (core_funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = core_addr[0];
            3'b010:  req_fault = |core_addr[1:0];
            3'b100:  req_fault = core_wr;
            3'b101:  req_fault = core_wr | core_addr[0];
            default: req_fault = 1'b1;
        endcase
    end

    // Lane formatting from the registered request; funct3[1:0] gives the size.
    always_comb begin
        be_fmt = 4'b1111;
        wd_fmt = data_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_fmt = 4'b0001 << addr_q[1:0];
                wd_fmt = {4{data_q[7:0]}};
            end
            2'b01: begin
                be_fmt = 4'b0011 << addr_q[1:0];
                wd_fmt = {2{data_q[15:0]}};
            end
            default: begin
                be_fmt = 4'b1111;
                wd_fmt = data_q;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_rd_data[7:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rd_data[7:0];
            2'd1:    byte_sel = mem_rd_data[15:8];
            2'd2:    byte_sel = mem_rd_data[23:16];
            default: byte_sel = mem_rd_data[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        load_fmt = mem_rd_data;
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = mem_rd_data;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and load result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wr_q      <= 1'b0;
            funct3_q  <= 3'd0;
            data_q    <= 32'd0;
            fault_q   <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            if (accept) begin
                addr_q   <= core_addr;
                wr_q     <= core_wr;
                funct3_q <= core_funct3;
                data_q   <= core_wr_data;
                fault_q  <= req_fault;
            end
            if ((state_q == S_ACCESS) && mem_ack && !wr_q) begin
                rd_data_q <= load_fmt;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (core_req) state_d = req_fault ? S_DONE : S_ACCESS;
            S_ACCESS: if (mem_ack)  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs: memory side is driven only in ACCESS so it reads as zero elsewhere.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = 4'd0;
        mem_wr_data = 32'd0;
        core_done   = 1'b0;
        core_fault  = 1'b0;
        case (state_q)
            S_ACCESS: begin
                mem_req     = 1'b1;
                mem_we      = wr_q;
                mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_be      = be_fmt;
                mem_wr_data = wd_fmt;
            end
            S_DONE: begin
                core_done  = 1'b1;
                core_fault = fault_q;
            end
            default: ;
        endcase
    end

    assign core_stall   = core_req && (state_q != S_DONE);
    assign core_rd_data = rd_data_q;

endmodule

// File: tb/tb_eka_lsu.sv
// tb/tb_eka_lsu.sv - self-checking bench for eka_lsu with a byte-lane reference model
module tb_eka_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_wr;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;
    logic        core_stall;
    logic        core_done;
    logic        core_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wr_data;
    logic        mem_ack;
    logic [31:0] mem_rd_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rd = 32'd0;

    always #5 clk = ~clk;

    eka_lsu #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_wr      (core_wr),
        .core_funct3  (core_funct3),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_stall   (core_stall),
        .core_done    (core_done),
        .core_fault   (core_fault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wr_data  (mem_wr_data),
        .mem_ack      (mem_ack),
        .mem_rd_data  (mem_rd_data)
    );

    typedef struct packed {
        logic [7:0]  done_lat;
        logic [7:0]  req_cycles;
        logic        fault;
        logic        we;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wd;
        logic        stable;
        logic        stall_ok;
    } obs_t;

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int model_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic model_fault(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
                (!wr && (f3 == 3'b100 || f3 == 3'b101));
        if (!legal) return 1'b1;
        return (addr % model_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int off;
        be  = 4'd0;
        off = int'(addr % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + model_size(f3));
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wd;
        int size;
        wd   = 32'd0;
        size = model_size(f3);
        for (int i = 0; i < 4; i++) wd = wd | (((data >> (8 * (i % size))) & 32'hFF) << (8 * i));
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        longint v;
        int size;
        int off;
        v    = 0;
        size = model_size(f3);
        off  = int'(addr % 4);
        for (int k = 0; k < size; k++) v = v + (longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k));
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    // Drives one core request and acts as the memory; called at posedge+1.
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int delay, input logic first_stall, output obs_t o);
        int  w;
        bit  seen;
        o          = '0;
        o.stable   = 1'b1;
        o.stall_ok = 1'b1;
        core_req     = 1'b1;
        core_wr      = wr;
        core_funct3  = f3;
        core_addr    = addr;
        core_wr_data = wdata;
        #1;
        if (first_stall && core_stall !== 1'b1) o.stall_ok = 1'b0;
        w    = 0;
        seen = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            mem_ack     = 1'b0;
            mem_rd_data = $urandom;
            if (core_done === 1'b1) begin
                o.done_lat = 8'(cyc);
                o.fault    = core_fault;
                if (core_stall !== 1'b0 || mem_req !== 1'b0) o.stall_ok = 1'b0;
                break;
            end
            if (core_stall !== 1'b1) o.stall_ok = 1'b0;
            if (mem_req === 1'b1) begin
                if (!seen) begin
                    o.we    = mem_we;
                    o.be    = mem_be;
                    o.maddr = mem_addr;
                    o.wd    = mem_wr_data;
                    seen    = 1;
                end else if (o.we !== mem_we || o.be !== mem_be || o.maddr !== mem_addr || o.wd !== mem_wr_data) begin
                    o.stable = 1'b0;
                end
                o.req_cycles = o.req_cycles + 8'd1;
                if (w == delay) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = rdata;
                end
                w++;
            end
        end
        core_req = 1'b0;
        mem_ack  = 1'b0;
        if (!model_fault(wr, f3, addr) && !wr) model_rd = model_load(f3, addr, rdata);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'd0) begin n_fail++; $display("FAIL reset_mem_ctl: req=%b we=%b be=%b expected 0 0 0000", mem_req, mem_we, mem_be); end
        n_checks++; if (mem_addr !== 32'd0 || mem_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_data: addr=%h wd=%h expected 0 0", mem_addr, mem_wr_data); end
        n_checks++; if (core_done !== 1'b0 || core_fault !== 1'b0 || core_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_core: done=%b fault=%b rd=%h expected 0 0 0", core_done, core_fault, core_rd_data); end
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        mem_ack = 1'b1;
        idle_cycle();
        idle_cycle();
        n_checks++; if (core_done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored: done=%b req=%b expected 0 0", core_done, mem_req); end
        mem_ack = 1'b0;
        model_rd = 32'd0;
    endtask

    task automatic test_lw();
        obs_t o;
        idle_cycle();
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, o);
        n_checks++; if (o.maddr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b0) begin n_fail++; $display("FAIL lw_mem: addr=%h be=%b we=%b expected 00000100 1111 0", o.maddr, o.be, o.we); end
        n_checks++; if (o.done_lat !== 8'd2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", o.done_lat); end
        n_checks++; if (core_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", core_rd_data); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        idle_cycle();
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, o);
        n_checks++; if (o.be !== 4'b1000 || core_rd_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: be=%b rd=%h expected 1000 ffffff80", o.be, core_rd_data); end
        idle_cycle();
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1, o);
        n_checks++; if (o.be !== 4'b1000 || core_rd_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu: be=%b rd=%h expected 1000 00000080", o.be, core_rd_data); end
    endtask

    task automatic test_sh_delay();
        obs_t o;
        idle_cycle();
        run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 1'b1, o);
        n_checks++; if (o.maddr !== 32'h200 || o.be !== 4'b1100 || o.wd !== 32'hABCDABCD || o.we !== 1'b1) begin n_fail++; $display("FAIL sh_mem: addr=%h be=%b wd=%h we=%b expected 00000200 1100 abcdabcd 1", o.maddr, o.be, o.wd, o.we); end
        n_checks++; if (o.req_cycles !== 8'd4 || o.stable !== 1'b1) begin n_fail++; $display("FAIL sh_hold: req_cycles=%0d stable=%b expected 4 1", o.req_cycles, o.stable); end
        n_checks++; if (o.stall_ok !== 1'b1 || o.done_lat !== 8'd5) begin n_fail++; $display("FAIL sh_stall: stall_ok=%b lat=%0d expected 1 5", o.stall_ok, o.done_lat); end
        n_checks++; if (core_rd_data !== 32'h00000080) begin n_fail++; $display("FAIL sh_rd_kept: got %h expected 00000080", core_rd_data); end
    endtask

    task automatic test_faults();
        obs_t o;
        logic        wrs [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] ads [3] = '{32'h101, 32'h001, 32'h100};
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            run_access(wrs[i], f3s[i], ads[i], 32'h55AA55AA, 32'h12345678, 0, 1'b1, o);
            n_checks++; if (o.fault !== 1'b1 || o.done_lat !== 8'd1 || o.req_cycles !== 8'd0) begin n_fail++; $display("FAIL fault_%0d: fault=%b lat=%0d req_cycles=%0d expected 1 1 0", i, o.fault, o.done_lat, o.req_cycles); end
            n_checks++; if (core_rd_data !== 32'h00000080) begin n_fail++; $display("FAIL fault_rd_kept_%0d: got %h expected 00000080", i, core_rd_data); end
        end
    endtask

    task automatic test_reset_midaccess();
        obs_t o;
        logic [31:0] word;
        idle_cycle();
        core_req     = 1'b1;
        core_wr      = 1'b1;
        core_funct3  = 3'b010;
        core_addr    = 32'h40;
        core_wr_data = 32'hCAFEF00D;
        idle_cycle();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: mem_req=%b expected 1", mem_req); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'd0 || mem_addr !== 32'd0 || mem_wr_data !== 32'd0 || core_done !== 1'b0 || core_rd_data !== 32'd0) begin
            n_fail++; $display("FAIL midreset_outputs: req=%b we=%b be=%b addr=%h wd=%h done=%b rd=%h expected all 0", mem_req, mem_we, mem_be, mem_addr, mem_wr_data, core_done, core_rd_data);
        end
        core_req = 1'b0;
        model_rd = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        word = $urandom;
        run_access(1'b0, 3'b101, 32'h46, 32'h0, word, 1, 1'b1, o);
        n_checks++; if (o.done_lat !== 8'd3 || o.fault !== 1'b0 || core_rd_data !== model_rd) begin n_fail++; $display("FAIL midreset_after: lat=%0d fault=%b rd=%h expected 3 0 %h", o.done_lat, o.fault, core_rd_data, model_rd); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        idle_cycle();
        run_access(1'b1, 3'b000, 32'h10, 32'h000000A5, 32'h0, 0, 1'b1, o1);
        run_access(1'b1, 3'b000, 32'h11, 32'h0000003C, 32'h0, 0, 1'b0, o2);
        n_checks++; if (o1.be !== 4'b0001 || o1.wd !== 32'hA5A5A5A5 || o1.done_lat !== 8'd2) begin n_fail++; $display("FAIL b2b_first: be=%b wd=%h lat=%0d expected 0001 a5a5a5a5 2", o1.be, o1.wd, o1.done_lat); end
        n_checks++; if (o2.be !== 4'b0010 || o2.wd !== 32'h3C3C3C3C || o2.done_lat !== 8'd3) begin n_fail++; $display("FAIL b2b_second: be=%b wd=%h spacing=%0d expected 0010 3c3c3c3c 3", o2.be, o2.wd, o2.done_lat); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          delay;
        bit          gap;
        int          exp_lat;
        logic        exp_fault;
        for (int n = 0; n < 60; n++) begin
            wr    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom & 32'h0000_0FFF;
            wdata = $urandom;
            rdata = $urandom;
            delay = $urandom_range(0, 3);
            gap   = 1'($urandom_range(0, 1));
            if (gap) idle_cycle();
            exp_fault = model_fault(wr, f3, addr);
            exp_lat   = (exp_fault ? 1 : delay + 2) + (gap ? 0 : 1);
            run_access(wr, f3, addr, wdata, rdata, delay, gap, o);
            n_checks++; if (o.fault !== exp_fault || o.done_lat !== 8'(exp_lat)) begin n_fail++; $display("FAIL rand_%0d_done: fault=%b lat=%0d expected %b %0d (wr=%b f3=%b addr=%h)", n, o.fault, o.done_lat, exp_fault, exp_lat, wr, f3, addr); end
            n_checks++; if (o.req_cycles !== 8'(exp_fault ? 0 : delay + 1) || o.stall_ok !== 1'b1) begin n_fail++; $display("FAIL rand_%0d_hs: req_cycles=%0d stall_ok=%b expected %0d 1", n, o.req_cycles, o.stall_ok, exp_fault ? 0 : delay + 1); end
            if (!exp_fault) begin
                n_checks++; if (o.maddr !== (addr & 32'hFFFF_FFFC) || o.be !== model_be(f3, addr) || o.we !== wr || o.stable !== 1'b1) begin
                    n_fail++; $display("FAIL rand_%0d_mem: addr=%h be=%b we=%b stable=%b expected %h %b %b 1", n, o.maddr, o.be, o.we, o.stable, addr & 32'hFFFF_FFFC, model_be(f3, addr), wr);
                end
                if (wr) begin
                    n_checks++; if (o.wd !== model_wd(f3, wdata)) begin n_fail++; $display("FAIL rand_%0d_wd: got %h expected %h", n, o.wd, model_wd(f3, wdata)); end
                end
            end
            n_checks++; if (core_rd_data !== model_rd) begin n_fail++; $display("FAIL rand_%0d_rd: got %h expected %h", n, core_rd_data, model_rd); end
        end
    endtask

    initial begin
        reset        = 1'b0;
        core_req     = 1'b0;
        core_wr      = 1'b0;
        core_funct3  = 3'd0;
        core_addr    = 32'd0;
        core_wr_data = 32'd0;
        mem_ack      = 1'b0;
        mem_rd_data  = 32'd0;
        #2;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_delay();
        test_faults();
        test_reset_midaccess();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
